// File: rtl/wash_phase_timer_if.sv
// wash_phase_timer control/status bundle between the cycle
// controller (master) and the phase timer (slave).
interface wash_phase_timer_if #(
    parameter int PHASES = 4,
    parameter int SEC_W  = 10
);
    localparam int PHW = (PHASES > 1) ? $clog2(PHASES) : 1;

    logic                    start;
    logic                    abort;
    logic                    pause;
    logic [PHW-1:0]          phase_sel;
    logic [1:0]              clk_freq;
    logic [PHASES*SEC_W-1:0] dur_table;
    logic                    busy;
    logic                    done;
    logic                    done_pulse;
    logic [PHW-1:0]          cur_phase;
    logic [SEC_W-1:0]        remaining;

    modport master (
        output start, abort, pause, phase_sel, clk_freq, dur_table,
        input  busy, done, done_pulse, cur_phase, remaining
    );

    modport slave (
        input  start, abort, pause, phase_sel, clk_freq, dur_table,
        output busy, done, done_pulse, cur_phase, remaining
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Generic washing-machine phase timer: 1 s prescaler, pause/abort/restart.
// Optional remaining-time readout enabled by WASH_PHASE_TIMER_REMAIN_EN.
module wash_phase_timer #(
    parameter int PHASES   = 4,
    parameter int SEC_W    = 10,
    parameter int BASE_CPS = 1_000_000
) (
    input logic              clk,
    input logic              rst,
    input logic              soft_rst,
    wash_phase_timer_if.slave bus
);
    localparam int PHW = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int PW  = $clog2(BASE_CPS * 8);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic [SEC_W-1:0] sec, sec_n;
    logic [PHW-1:0]   phase_q, phase_n;
    logic [1:0]       freq_q, freq_n;
    logic [SEC_W-1:0] dur_q, dur_n;
    logic             pulse_q, pulse_n;

    logic [SEC_W-1:0] sel_dur;
    logic [SEC_W-1:0] sec_inc;
    logic [PW:0]      cps;
    logic             tick;
    logic             clear;

    assign clear   = rst || !soft_rst;
    assign sel_dur = bus.dur_table[bus.phase_sel*SEC_W +: SEC_W];
    assign sec_inc = sec + 1'b1;
    assign cps     = (PW+1)'(BASE_CPS) << freq_q;
    assign tick    = ({1'b0, presc} == (cps - 1'b1));

    // next-state, counter and done-pulse decode in priority order
    always_comb begin
        state_n = state;
        presc_n = presc;
        sec_n   = sec;
        phase_n = phase_q;
        freq_n  = freq_q;
        dur_n   = dur_q;
        pulse_n = 1'b0;
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
        end else if (bus.start && (state == IDLE || state == DONE)) begin
            phase_n = bus.phase_sel;
            freq_n  = bus.clk_freq;
            dur_n   = sel_dur;
            presc_n = '0;
            sec_n   = '0;
            if (sel_dur == '0) begin
                state_n = DONE;
                pulse_n = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state == RUN && bus.pause) begin
            state_n = PAUSE;
        end else if (state == RUN || (state == PAUSE && !bus.pause)) begin
            state_n = RUN;
            if (tick) begin
                presc_n = '0;
                sec_n   = sec_inc;
                if (sec_inc == dur_q) begin
                    state_n = DONE;
                    pulse_n = 1'b1;
                end
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    // state and datapath registers with synchronous clears
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            presc   <= '0;
            sec     <= '0;
            phase_q <= '0;
            freq_q  <= '0;
            dur_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            sec     <= sec_n;
            phase_q <= phase_n;
            freq_q  <= freq_n;
            dur_q   <= dur_n;
            pulse_q <= pulse_n;
        end
    end

    assign bus.busy       = (state == RUN) || (state == PAUSE);
    assign bus.done       = (state == DONE);
    assign bus.done_pulse = pulse_q;
    assign bus.cur_phase  = (state == IDLE) ? '0 : phase_q;

`ifdef WASH_PHASE_TIMER_REMAIN_EN
    assign bus.remaining  = bus.busy ? (dur_q - sec) : '0;
`else
    assign bus.remaining  = '0;
`endif
endmodule
